alu_arbiter: RTL

//   Shares one combinational ALU between NREQ requesters (e.g. integer pipe, AUIPC/branch-target unit).

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_rr_pick.sv | 33 +++
 rtl/alu_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: op codes, default widths,
// the request payload record and the round-robin wrap helper.
package alu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned SEL_SIZE   = 4;
  localparam int unsigned SHIFT_SIZE = 5;
  localparam int unsigned TAG_W      = 4;

  typedef enum logic [SEL_SIZE-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLT   = 4'd2,
    ALU_SLTU  = 4'd3,
    ALU_AND   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [SEL_SIZE-1:0]   sel;
    logic [SHIFT_SIZE-1:0] shamt;
    logic [XLEN-1:0]       a;
    logic [XLEN-1:0]       b;
    logic [TAG_W-1:0]      tag;
  } alu_req_t;

  // Index following idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first set valid bit at or after ptr,
// wrapping modulo NREQ. Produces a one-hot grant and the winner index.
module alu_rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   winner,
  output logic            any
);

  int unsigned idx;

  // Scan from ptr around the ring; the first valid requester wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && valid[idx]) begin
        any         = 1'b1;
        grant[idx]  = 1'b1;
        winner      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters,
// with a 1-entry registered response buffer.
// Optional feature: define ALU_ARB_PERF_EN to add per-requester grant and
// stall performance counters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned XLEN       = alu_pkg::XLEN,
  parameter int unsigned SEL_SIZE   = alu_pkg::SEL_SIZE,
  parameter int unsigned SHIFT_SIZE = alu_pkg::SHIFT_SIZE,
  parameter int unsigned TAG_W      = alu_pkg::TAG_W,
  localparam int unsigned IW        = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*SEL_SIZE-1:0]   req_sel,
  input  logic [NREQ*SHIFT_SIZE-1:0] req_shamt,
  input  logic [NREQ*XLEN-1:0]       req_a,
  input  logic [NREQ*XLEN-1:0]       req_b,
  input  logic [NREQ*TAG_W-1:0]      req_tag,
  input  logic                       flush,
  output logic                       alu_enable,
  output logic [SEL_SIZE-1:0]        alu_sel,
  output logic [SHIFT_SIZE-1:0]      alu_shamt,
  output logic [XLEN-1:0]            alu_a,
  output logic [XLEN-1:0]            alu_b,
  input  logic [XLEN-1:0]            alu_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [XLEN-1:0]            rsp_data,
  output logic [IW-1:0]              rsp_id,
  output logic [TAG_W-1:0]           rsp_tag
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0]         perf_grant_cnt,
  output logic [31:0]                perf_stall_cnt
`endif
);

  logic            accept;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   winner;
  logic            grant_any;
  logic [TAG_W-1:0] win_tag;

  // Buffer can take a new result when empty or being drained, and not flushed.
  always_comb begin
    accept = !flush && (!rsp_valid || rsp_ready);
  end

  alu_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .valid  (req_valid & {NREQ{accept}}),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner),
    .any    (grant_any)
  );

  assign req_ready = grant;

  // Route the granted payload to the ALU; everything zero when idle.
  always_comb begin
    alu_enable = grant_any;
    alu_sel    = '0;
    alu_shamt  = '0;
    alu_a      = '0;
    alu_b      = '0;
    win_tag    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_sel   = req_sel[i*SEL_SIZE +: SEL_SIZE];
        alu_shamt = req_shamt[i*SHIFT_SIZE +: SHIFT_SIZE];
        alu_a     = req_a[i*XLEN +: XLEN];
        alu_b     = req_b[i*XLEN +: XLEN];
        win_tag   = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Response buffer and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_tag   <= '0;
      ptr       <= '0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (grant_any) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_result;
      rsp_id    <= winner;
      rsp_tag   <= win_tag;
      ptr       <= IW'(rr_next(32'(winner), NREQ));
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [31:0] grant_cnt [NREQ];
  logic [31:0] stall_cnt;

  // Performance counters; flush cycles are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else if (!flush) begin
      for (int unsigned i = 0; i < NREQ; i++) grant_cnt[i] <= grant_cnt[i] + 32'(grant[i]);
      if (|req_valid && !grant_any) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Flatten the grant counters onto the output bus.
  always_comb begin
    perf_grant_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) perf_grant_cnt[i*32 +: 32] = grant_cnt[i];
  end

  assign perf_stall_cnt = stall_cnt;
`endif

endmodule
